// File: rtl/frame_scan_addr_pkg.sv
// frame_scan_addr_pkg: shared types and default geometry for the frame
// scan address generator (state encoding, marker bundle, counter sizing).
package frame_scan_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HGAP   = 2'd2,
    ST_VGAP   = 2'd3
  } scan_state_e;

  // Default geometry: 40 words x 480 lines of a 16-bit addressed memory.
  localparam int FRAME_ADDR_W  = 16;
  localparam int FRAME_H_WORDS = 40;
  localparam int FRAME_V_LINES = 480;

  // Per-read markers travelling alongside the memory latency.
  typedef struct packed {
    logic rd;   // read issued
    logic ls;   // first word of a line
    logic fs;   // first word of a frame
  } mark_t;

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_scan_addr_if.sv
// frame_scan_addr_if: control inputs and memory-port/marker outputs of
// frame_scan_addr. With FRAME_DBUF_EN defined it also carries the
// swap_req / buf_sel double-buffer pair.
interface frame_scan_addr_if
  import frame_scan_addr_pkg::*;
#(
  parameter int ADDR_W = FRAME_ADDR_W
);
  logic              ce;
  logic              run;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              data_valid;
  logic              line_start;
  logic              frame_start;
  logic              busy;
`ifdef FRAME_DBUF_EN
  logic              swap_req;
  logic              buf_sel;
`endif

  // Upstream controller / memory consumer side.
  modport master (
`ifdef FRAME_DBUF_EN
    output swap_req,
    input  buf_sel,
`endif
    output ce, run,
    input  addr, rd_en, data_valid, line_start, frame_start, busy
  );

  // Address generator side.
  modport slave (
`ifdef FRAME_DBUF_EN
    input  swap_req,
    output buf_sel,
`endif
    input  ce, run,
    output addr, rd_en, data_valid, line_start, frame_start, busy
  );
endinterface

// File: rtl/scan_delay_line.sv
// scan_delay_line: DEPTH-stage shift register, clocked every clk
// (independent of the clock enable), cleared by the async reset.
module scan_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  // Shift one stage per clk; stage 0 takes the new input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/frame_scan_addr.sv
// frame_scan_addr: raster address generator for the frame block memory.
// Walks H_WORDS x V_LINES words with H_GAP idle ticks between lines and
// V_GAP idle ticks after the frame, advancing only on ce ticks. Markers
// are delayed MEM_LAT clks to line up with the memory's registered dout.
// Optional macro FRAME_DBUF_EN: double buffering via swap_req / buf_sel,
// base address toggling between 0 and 2^(ADDR_W-1) at frame boundaries.
module frame_scan_addr
  import frame_scan_addr_pkg::*;
#(
  parameter int ADDR_W  = FRAME_ADDR_W,
  parameter int H_WORDS = FRAME_H_WORDS,
  parameter int V_LINES = FRAME_V_LINES,
  parameter int H_GAP   = 8,
  parameter int V_GAP   = 16,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  frame_scan_addr_if.slave bus
);
  localparam int XW = cnt_w(H_WORDS);
  localparam int YW = cnt_w(V_LINES);
  localparam int GW = cnt_w((H_GAP > V_GAP) ? H_GAP : V_GAP);

  localparam logic [XW-1:0] X_LAST  = XW'(H_WORDS - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_LINES - 1);
  localparam logic [GW-1:0] HG_LAST = GW'(H_GAP - 1);
  localparam logic [GW-1:0] VG_LAST = GW'(V_GAP - 1);

  scan_state_e       state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [GW-1:0]     g_q, g_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;

  // base_cur: buffer of the frame in progress (used when leaving IDLE).
  // base_nxt: buffer of the next frame once any pending swap is applied.
  logic [ADDR_W-1:0] base_cur, base_nxt;

`ifdef FRAME_DBUF_EN
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(1) << (ADDR_W - 1);

  logic sel_q, sel_d;
  logic pend_q, pend_d;
  logic swap_now;

  // A request arriving on the very cycle of the frame boundary still counts.
  assign swap_now    = pend_q | bus.swap_req;
  assign base_cur    = sel_q ? HALF : '0;
  assign base_nxt    = (sel_q ^ swap_now) ? HALF : '0;
  assign bus.buf_sel = sel_q;
`else
  assign base_cur = '0;
  assign base_nxt = '0;
`endif

  // Next-state: everything holds unless ce; rd/markers are one-clk pulses.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    g_d     = g_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
`ifdef FRAME_DBUF_EN
    sel_d   = sel_q;
    pend_d  = swap_now;
`endif
    if (bus.ce) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.run) begin
            state_d = ST_ACTIVE;
            addr_d  = base_cur;
            x_d     = '0;
            y_d     = '0;
            rd_d    = 1'b1;
            ls_d    = 1'b1;
            fs_d    = 1'b1;
          end
        end
        ST_ACTIVE: begin
          // The read for (x_q, addr_q) is already out; step past it.
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            g_d     = '0;
            state_d = (y_q == Y_LAST) ? ST_VGAP : ST_HGAP;
          end else begin
            x_d  = x_q + 1'b1;
            rd_d = 1'b1;
          end
        end
        ST_HGAP: begin
          if (g_q == HG_LAST) begin
            // addr_q already points at the first word of the next line.
            state_d = ST_ACTIVE;
            x_d     = '0;
            y_d     = y_q + 1'b1;
            rd_d    = 1'b1;
            ls_d    = 1'b1;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
        ST_VGAP: begin
          if (g_q == VG_LAST) begin
            // Only frame boundary: run is sampled and the buffer may swap.
`ifdef FRAME_DBUF_EN
            sel_d  = sel_q ^ swap_now;
            pend_d = 1'b0;
`endif
            x_d = '0;
            y_d = '0;
            if (bus.run) begin
              state_d = ST_ACTIVE;
              addr_d  = base_nxt;
              rd_d    = 1'b1;
              ls_d    = 1'b1;
              fs_d    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            g_d = g_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered memory-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

`ifdef FRAME_DBUF_EN
  // Buffer select and sticky swap request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      pend_q <= pend_d;
    end
  end
`endif

  mark_t mk_in, mk_out;
  assign mk_in = {rd_q, ls_q, fs_q};

  scan_delay_line #(
    .DEPTH(MEM_LAT),
    .WIDTH($bits(mark_t))
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .d_i  (mk_in),
    .q_o  (mk_out)
  );

  assign bus.addr        = addr_q;
  assign bus.rd_en       = rd_q;
  assign bus.data_valid  = mk_out.rd;
  assign bus.line_start  = mk_out.ls;
  assign bus.frame_start = mk_out.fs;
  assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_frame_scan_addr.sv
// tb_frame_scan_addr: directed bench for frame_scan_addr with a tick-index
// reference model (frame position -> read/address/markers by arithmetic)
// checked every cycle, plus literal expectations for the key sequences.
// Define FRAME_DBUF_EN to include the double-buffer scenario.
module tb_frame_scan_addr;
  localparam int ADDR_W  = 16;
  localparam int H_WORDS = 4;
  localparam int V_LINES = 3;
  localparam int H_GAP   = 2;
  localparam int V_GAP   = 3;
  localparam int MEM_LAT = 1;
  localparam int LINE_T  = H_WORDS + H_GAP;
  localparam int ACT_T   = (V_LINES - 1) * LINE_T + H_WORDS;
  localparam int FRAME_T = ACT_T + V_GAP;

  logic clk = 1'b0;
  logic reset = 1'b0;

  frame_scan_addr_if #(.ADDR_W(ADDR_W)) bus();

  frame_scan_addr #(
    .ADDR_W (ADDR_W),
    .H_WORDS(H_WORDS),
    .V_LINES(V_LINES),
    .H_GAP  (H_GAP),
    .V_GAP  (V_GAP),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_act  = 1'b0;
  bit              m_sel  = 1'b0;
  bit              m_pend = 1'b0;
  int              m_t    = 0;
  bit              e_rd   = 1'b0;
  bit              e_ls   = 1'b0;
  bit              e_fs   = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  bit [2:0]        e_dly [MEM_LAT] = '{default: 3'b000};

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_act = 0; m_sel = 0; m_pend = 0; m_t = 0;
      e_rd = 0; e_ls = 0; e_fs = 0; e_addr = '0;
      for (int i = 0; i < MEM_LAT; i++) e_dly[i] = 3'b000;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) e_dly[i] = e_dly[i-1];
      e_dly[0] = {e_rd, e_ls, e_fs};
`ifdef FRAME_DBUF_EN
      if (bus.swap_req) m_pend = 1;
`endif
      e_rd = 0; e_ls = 0; e_fs = 0;
      if (bus.ce) begin
        if (!m_act) begin
          if (bus.run) begin m_act = 1; m_t = 0; end
        end else begin
          m_t++;
          if (m_t == FRAME_T) begin
            if (m_pend) begin m_sel = ~m_sel; m_pend = 0; end
            m_t   = 0;
            m_act = bus.run;
          end
        end
        if (m_act && m_t < ACT_T && (m_t % LINE_T) < H_WORDS) begin
          e_rd   = 1;
          e_addr = {m_sel, 15'd0} + 16'((m_t / LINE_T) * H_WORDS + (m_t % LINE_T));
          e_ls   = (m_t % LINE_T) == 0;
          e_fs   = (m_t == 0);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("rst_rd_en", 32'(bus.rd_en), 0);
      chk("rst_addr", 32'(bus.addr), 0);
      chk("rst_data_valid", 32'(bus.data_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
    end else begin
      chk("rd_en", 32'(bus.rd_en), 32'(e_rd));
      if (e_rd) chk("addr", 32'(bus.addr), 32'(e_addr));
      chk("data_valid", 32'(bus.data_valid), 32'(e_dly[MEM_LAT-1][2]));
      chk("line_start", 32'(bus.line_start), 32'(e_dly[MEM_LAT-1][1]));
      chk("frame_start", 32'(bus.frame_start), 32'(e_dly[MEM_LAT-1][0]));
      chk("busy", 32'(bus.busy), 32'(m_act));
`ifdef FRAME_DBUF_EN
      chk("buf_sel", 32'(bus.buf_sel), 32'(m_sel));
`endif
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle(input int lim);
    int k = 0;
    while (bus.busy && k < lim) begin @(negedge clk); k++; end
    chk("drain_busy", 32'(bus.busy), 0);
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a, input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!(bus.rd_en && bus.addr == a) && k < lim);
    chk("reach_addr", 32'(bus.rd_en && bus.addr == a), 1);
  endtask

  // Hand-derived single-frame pattern (sample index = frame tick).
  bit pat_rd [19] = '{1,1,1,1,0,0,1,1,1,1,0,0,1,1,1,1,0,0,0};
  int pat_ad [19] = '{0,1,2,3,-1,-1,4,5,6,7,-1,-1,8,9,10,11,-1,-1,-1};

  bit              rd_h [40];
  logic [ADDR_W-1:0] ad_h [40];
  bit              ls_h [40];
  bit              fs_h [40];
  bit              dv_h [40];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int nrd;
    int nrd1;
    int k;
    bit prev_ce;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] ra [16];

    bus.ce = 0;
    bus.run = 0;
`ifdef FRAME_DBUF_EN
    bus.swap_req = 0;
`endif
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Tests 1/2: continuous ce, run=1.
    bus.ce = 1;
    bus.run = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd_h[i] = bus.rd_en; ad_h[i] = bus.addr;
      ls_h[i] = bus.line_start; fs_h[i] = bus.frame_start; dv_h[i] = bus.data_valid;
    end
    nrd1 = 0;
    for (int i = 0; i < 19; i++) nrd1 += int'(rd_h[i]);
    chk("reads_per_frame", 32'(nrd1), 12);
    for (int i = 0; i < 38; i++) begin
      chk("t1_rd", 32'(rd_h[i]), 32'(pat_rd[i % 19]));
      if (pat_ad[i % 19] >= 0) chk("t1_addr", 32'(ad_h[i]), 32'(pat_ad[i % 19]));
      if (i >= 1) begin
        chk("t2_dv", 32'(dv_h[i]), 32'(pat_rd[(i-1) % 19]));
        chk("t2_ls", 32'(ls_h[i]),
            32'(((i-1) % 19 == 0) || ((i-1) % 19 == 6) || ((i-1) % 19 == 12)));
        chk("t2_fs", 32'(fs_h[i]), 32'((i-1) % 19 == 0));
      end
    end
    bus.run = 0;
    wait_idle(60);

    // Test 3: ce every 3rd clk.
    bus.run = 1;
    prev_ce = 1; prev_addr = bus.addr; nrd = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (!prev_ce) begin
        chk("t3_hold_addr", 32'(bus.addr), 32'(prev_addr));
        chk("t3_rd_off", 32'(bus.rd_en), 0);
      end
      if (bus.rd_en) begin
        if (nrd < 16) ra[nrd] = bus.addr;
        nrd++;
      end
      prev_addr = bus.addr;
      bus.ce = (c % 3 == 0);
      prev_ce = bus.ce;
    end
    chk("t3_nreads", 32'(nrd >= 16), 1);
    for (int i = 0; i < 16; i++) chk("t3_addr_seq", 32'(ra[i]), 32'(i % 12));

    // Test 4: drop run at addr 5; frame completes then IDLE.
    bus.ce = 1;
    wait_rd(16'd5, 80);
    bus.run = 0;
    nrd = 0; last = '0; k = 0;
    while (bus.busy && k < 60) begin
      @(negedge clk); k++;
      if (bus.rd_en) begin nrd++; last = bus.addr; end
    end
    chk("t4_tail_reads", 32'(nrd), 6);
    chk("t4_last_addr", 32'(last), 11);
    chk("t4_busy", 32'(bus.busy), 0);
    nrd = 0;
    repeat (20) begin @(negedge clk); nrd += int'(bus.rd_en); end
    chk("t4_no_reads", 32'(nrd), 0);

    // Test 5: async reset mid-frame, then restart.
    bus.run = 1;
    wait_rd(16'd6, 60);
    #2 reset = 0;
    #1;
    chk("t5_rd_en", 32'(bus.rd_en), 0);
    chk("t5_addr", 32'(bus.addr), 0);
    chk("t5_dv", 32'(bus.data_valid), 0);
    chk("t5_ls", 32'(bus.line_start), 0);
    chk("t5_fs", 32'(bus.frame_start), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("t5_restart_rd", 32'(bus.rd_en), 1);
    chk("t5_restart_addr", 32'(bus.addr), 0);
    @(negedge clk);
    chk("t5_restart_fs", 32'(bus.frame_start), 1);

`ifdef FRAME_DBUF_EN
    // Test 6: swap request mid-frame takes effect at the next frame.
    wait_rd(16'd2, 20);
    bus.swap_req = 1;
    @(negedge clk);
    bus.swap_req = 0;
    chk("t6_sel_mid", 32'(bus.buf_sel), 0);
    wait_rd(16'h8000, 60);
    chk("t6_buf_sel", 32'(bus.buf_sel), 1);
    wait_rd(16'h800B, 30);
`endif

    bus.run = 0;
    wait_idle(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
